// File: rtl/plic_ctx_arbiter_if.sv
// Per-context PLIC arbiter bundle: gateway/enable/priority inputs,
// claim/complete strobes, and winner/clear/irq outputs.
interface plic_ctx_arbiter_if #(
  parameter int irqmax = 73,
  parameter int prio_w = 4
);
  localparam int id_w = $clog2(irqmax);

  logic [irqmax-1:0]        i_pending;
  logic [irqmax-1:0]        i_enable;
  logic [irqmax*prio_w-1:0] i_prio;
  logic [prio_w-1:0]        i_threshold;
  logic                     i_claim;
  logic [id_w-1:0]          o_claim_id;
  logic                     i_complete;
  logic [id_w-1:0]          i_complete_id;
  logic                     o_clear_valid;
  logic [id_w-1:0]          o_clear_id;
  logic [id_w-1:0]          o_best_id;
  logic [prio_w-1:0]        o_best_prio;
  logic                     o_sweep_done;
  logic                     o_irq;

  modport master (
    output i_pending, i_enable, i_prio, i_threshold,
    output i_claim, i_complete, i_complete_id,
    input  o_claim_id, o_clear_valid, o_clear_id,
    input  o_best_id, o_best_prio, o_sweep_done, o_irq
  );

  modport slave (
    input  i_pending, i_enable, i_prio, i_threshold,
    input  i_claim, i_complete, i_complete_id,
    output o_claim_id, o_clear_valid, o_clear_id,
    output o_best_id, o_best_prio, o_sweep_done, o_irq
  );
endinterface

// File: rtl/plic_ctx_arbiter.sv
// Per-context PLIC arbiter: serial one-source-per-clock priority sweep
// with claim/complete in-service tracking.
module plic_ctx_arbiter #(
  parameter int irqmax = 73,
  parameter int prio_w = 4
) (
  input logic               i_clk,
  input logic               i_nrst,
  plic_ctx_arbiter_if.slave bus
);
  localparam int id_w = $clog2(irqmax);
  localparam logic [id_w-1:0] last_id = id_w'(irqmax - 1);

  logic [id_w-1:0]   idx;
  logic [id_w-1:0]   cand_id;
  logic [prio_w-1:0] cand_prio;
  logic [id_w-1:0]   best_id;
  logic [prio_w-1:0] best_prio;
  logic [id_w-1:0]   claim_id;
  logic [id_w-1:0]   clear_id;
  logic              clear_valid;
  logic              sweep_done;
  logic [irqmax-1:0] inservice;
  logic [irqmax-1:0] inservice_nxt;

  logic [prio_w-1:0] prio_arr [irqmax];
  logic [prio_w-1:0] cur_prio;
  logic              elig;
  logic              take;
  logic              last;
  logic              claim_hit;
  logic              cmpl_ok;
  logic [id_w-1:0]   nxt_id;
  logic [prio_w-1:0] nxt_prio;

  always_comb begin
    for (int n = 0; n < irqmax; n++) begin
      prio_arr[n] = bus.i_prio[n*prio_w +: prio_w];
    end
  end

  always_comb begin
    cur_prio  = prio_arr[idx];
    elig      = bus.i_pending[idx] & bus.i_enable[idx]
              & ~inservice[idx] & (cur_prio != '0);
    take      = elig && (cur_prio > cand_prio);
    nxt_id    = take ? idx : cand_id;
    nxt_prio  = take ? cur_prio : cand_prio;
    last      = (idx == last_id);
    claim_hit = bus.i_claim && (best_id != '0);
    cmpl_ok   = bus.i_complete && (bus.i_complete_id != '0)
              && (bus.i_complete_id <= last_id);
  end

  // Claim is applied after complete so a same-id collision leaves the bit set.
  always_comb begin
    inservice_nxt = inservice;
    if (cmpl_ok) inservice_nxt[bus.i_complete_id] = 1'b0;
    if (claim_hit) inservice_nxt[best_id] = 1'b1;
    inservice_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      idx         <= id_w'(1);
      cand_id     <= '0;
      cand_prio   <= '0;
      best_id     <= '0;
      best_prio   <= '0;
      claim_id    <= '0;
      clear_id    <= '0;
      clear_valid <= 1'b0;
      sweep_done  <= 1'b0;
      inservice   <= '0;
    end else begin
      clear_valid <= 1'b0;
      sweep_done  <= 1'b0;
      inservice   <= inservice_nxt;
      if (bus.i_claim) claim_id <= claim_hit ? best_id : '0;
      if (claim_hit) begin
        clear_valid <= 1'b1;
        clear_id    <= best_id;
        best_id     <= '0;
        best_prio   <= '0;
        idx         <= id_w'(1);
        cand_id     <= '0;
        cand_prio   <= '0;
      end else if (last) begin
        best_id    <= nxt_id;
        best_prio  <= nxt_prio;
        sweep_done <= 1'b1;
        idx        <= id_w'(1);
        cand_id    <= '0;
        cand_prio  <= '0;
      end else begin
        idx       <= idx + id_w'(1);
        cand_id   <= nxt_id;
        cand_prio <= nxt_prio;
      end
    end
  end

  assign bus.o_claim_id    = claim_id;
  assign bus.o_clear_valid = clear_valid;
  assign bus.o_clear_id    = clear_id;
  assign bus.o_best_id     = best_id;
  assign bus.o_best_prio   = best_prio;
  assign bus.o_sweep_done  = sweep_done;
  assign bus.o_irq = (best_id != '0) && (best_prio > bus.i_threshold);
endmodule

// File: tb/tb_plic_ctx_arbiter.sv
// Directed bench for plic_ctx_arbiter: sweep timing, priority/tie,
// threshold, claim/complete and asynchronous reset.
module tb_plic_ctx_arbiter;
  localparam int irqmax = 73;
  localparam int prio_w = 4;

  typedef struct {
    logic [6:0] id;
    logic       clr;
  } exp_t;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;
  exp_t exp_q [$];

  plic_ctx_arbiter_if #(.irqmax(irqmax), .prio_w(prio_w)) bus ();

  plic_ctx_arbiter #(.irqmax(irqmax), .prio_w(prio_w)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int n, input bit on, input int p);
    bus.i_pending[n] = on;
    bus.i_enable[n]  = on;
    bus.i_prio[n*prio_w +: prio_w] = prio_w'(p);
  endtask

  task automatic wait_sweeps(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 80 * n) begin
      @(negedge clk);
      cyc++;
      if (bus.o_sweep_done) seen++;
    end
    chk("sweep_wait", seen, n);
  endtask

  task automatic do_claim(input logic [6:0] exp_id, input logic exp_clr,
                          input bit with_cmp, input logic [6:0] cmp_id);
    exp_t e;
    bus.i_claim       = 1'b1;
    bus.i_complete    = with_cmp;
    bus.i_complete_id = cmp_id;
    e.id  = exp_id;
    e.clr = exp_clr;
    exp_q.push_back(e);
    @(negedge clk);
    bus.i_claim    = 1'b0;
    bus.i_complete = 1'b0;
    e = exp_q.pop_front();
    chk("claim_id", bus.o_claim_id, e.id);
    chk("clear_valid", bus.o_clear_valid, e.clr);
    if (e.clr) begin
      chk("clear_id", bus.o_clear_id, e.id);
      chk("best_cleared", bus.o_best_id, 0);
    end
    @(negedge clk);
    chk("clear_pulse_end", bus.o_clear_valid, 0);
  endtask

  task automatic do_complete(input logic [6:0] id);
    bus.i_complete    = 1'b1;
    bus.i_complete_id = id;
    @(negedge clk);
    bus.i_complete = 1'b0;
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    bus.i_pending     = '0;
    bus.i_enable      = '0;
    bus.i_prio        = '0;
    bus.i_threshold   = '0;
    bus.i_claim       = 1'b0;
    bus.i_complete    = 1'b0;
    bus.i_complete_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_best_id", bus.o_best_id, 0);
    chk("rst_best_prio", bus.o_best_prio, 0);
    chk("rst_claim_id", bus.o_claim_id, 0);
    chk("rst_clear_valid", bus.o_clear_valid, 0);
    chk("rst_sweep_done", bus.o_sweep_done, 0);
    chk("rst_irq", bus.o_irq, 0);
    nrst = 1'b1;

    // 1: single source, latency and sweep period
    set_src(5, 1, 3);
    cyc = 0;
    while (bus.o_best_id !== 7'd5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t1_latency_ok", cyc <= 144, 1);
    chk("t1_best_id", bus.o_best_id, 5);
    chk("t1_best_prio", bus.o_best_prio, 3);
    chk("t1_irq", bus.o_irq, 1);
    wait_sweeps(1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.o_sweep_done && cyc < 200);
    chk("t1_period", cyc, 72);

    // 2: highest priority, claim, then next winner
    set_src(5, 0, 0);
    set_src(7, 1, 2);
    set_src(9, 1, 6);
    set_src(12, 1, 6);
    wait_sweeps(2);
    chk("t2_best_id", bus.o_best_id, 9);
    chk("t2_best_prio", bus.o_best_prio, 6);
    do_claim(7'd9, 1'b1, 1'b0, 7'd0);
    wait_sweeps(1);
    chk("t2_next_id", bus.o_best_id, 12);
    chk("t2_next_prio", bus.o_best_prio, 6);

    // 4: claim and complete of the same id in one cycle
    set_src(7, 0, 0);
    set_src(12, 0, 0);
    do_complete(7'd9);
    wait_sweeps(2);
    chk("t4_reelig", bus.o_best_id, 9);
    do_claim(7'd9, 1'b1, 1'b1, 7'd9);
    wait_sweeps(2);
    chk("t4_still_insvc", bus.o_best_id, 0);
    do_complete(7'd9);
    wait_sweeps(2);
    chk("t4_after_cmpl", bus.o_best_id, 9);

    // 5: empty claim and out-of-range completes
    do_claim(7'd9, 1'b1, 1'b0, 7'd0);
    do_claim(7'd0, 1'b0, 1'b0, 7'd0);
    do_complete(7'd0);
    do_complete(7'd100);
    wait_sweeps(2);
    chk("t5_no_change", bus.o_best_id, 0);
    chk("t5_irq", bus.o_irq, 0);
    do_complete(7'd9);
    wait_sweeps(2);
    chk("t5_cmpl9", bus.o_best_id, 9);
    set_src(9, 0, 0);

    // 3: equal priority tie and live threshold
    set_src(3, 1, 4);
    set_src(40, 1, 4);
    wait_sweeps(2);
    chk("t3_tie_id", bus.o_best_id, 3);
    chk("t3_tie_prio", bus.o_best_prio, 4);
    chk("t3_irq_thr0", bus.o_irq, 1);
    bus.i_threshold = 4'd4;
    #1;
    chk("t3_irq_thr4", bus.o_irq, 0);
    bus.i_threshold = 4'd3;
    #1;
    chk("t3_irq_thr3", bus.o_irq, 1);
    set_src(3, 0, 0);
    set_src(40, 0, 0);
    bus.i_threshold = 4'd0;

    // 6: asynchronous reset mid-sweep
    set_src(5, 1, 7);
    wait_sweeps(2);
    chk("t6_best_id", bus.o_best_id, 5);
    repeat (10) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t6_rst_best_id", bus.o_best_id, 0);
    chk("t6_rst_best_prio", bus.o_best_prio, 0);
    chk("t6_rst_irq", bus.o_irq, 0);
    chk("t6_rst_sweep", bus.o_sweep_done, 0);
    @(negedge clk);
    nrst = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.o_sweep_done && cyc < 200);
    chk("t6_restart_len", cyc, 72);
    chk("t6_recommit", bus.o_best_id, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
